// File: rtl/decode_execute_reg.sv
// decode_execute_reg: pipeline register between the decode (D) and execute (E)
// stages of an in-order core, with stall/flush control and two performance
// counters.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   StallE_i          hold the E-stage contents
//   FlushE_i          replace the E-stage contents with a bubble (wins over stall)
//   ValidD_i          decode slot holds a real instruction
//   *D_i              decode-stage control, operands, PC values, register indices
//   *E_o              registered E-stage copies of every *D_i input
//   ValidE_o          E slot holds a real instruction
//   StallCnt_o        edges on which a valid E instruction was held by a stall
//   BubbleCnt_o       edges on which a bubble entered the E stage
module decode_execute_reg #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CONTROL_WIDTH = 3,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     StallE_i,
  input  logic                     FlushE_i,
  input  logic                     ValidD_i,

  input  logic [2:0]               RegWriteD_i,
  input  logic [1:0]               ResultSrcD_i,
  input  logic [1:0]               MemWriteD_i,
  input  logic [CONTROL_WIDTH-1:0] ALUctrlD_i,
  input  logic                     ALUsrcD_i,
  input  logic                     BranchD_i,
  input  logic                     JumpD_i,

  input  logic [DATA_WIDTH-1:0]    RD1D_i,
  input  logic [DATA_WIDTH-1:0]    RD2D_i,
  input  logic [DATA_WIDTH-1:0]    ImmExtD_i,
  input  logic [DATA_WIDTH-1:0]    PCD_i,
  input  logic [DATA_WIDTH-1:0]    PCPlus4D_i,
  input  logic [4:0]               Rs1D_i,
  input  logic [4:0]               Rs2D_i,
  input  logic [4:0]               RdD_i,

  output logic [2:0]               RegWriteE_o,
  output logic [1:0]               ResultSrcE_o,
  output logic [1:0]               MemWriteE_o,
  output logic [CONTROL_WIDTH-1:0] ALUctrlE_o,
  output logic                     ALUsrcE_o,
  output logic                     BranchE_o,
  output logic                     JumpE_o,

  output logic [DATA_WIDTH-1:0]    RD1E_o,
  output logic [DATA_WIDTH-1:0]    RD2E_o,
  output logic [DATA_WIDTH-1:0]    ImmExtE_o,
  output logic [DATA_WIDTH-1:0]    PCE_o,
  output logic [DATA_WIDTH-1:0]    PCPlus4E_o,
  output logic [4:0]               Rs1E_o,
  output logic [4:0]               Rs2E_o,
  output logic [4:0]               RdE_o,

  output logic                     ValidE_o,
  output logic [CNT_WIDTH-1:0]     StallCnt_o,
  output logic [CNT_WIDTH-1:0]     BubbleCnt_o
);

  // Rule decode: flush beats stall, load only when neither applies.
  logic do_flush;
  logic do_stall;
  logic do_load;

  assign do_flush = FlushE_i;
  assign do_stall = StallE_i & ~FlushE_i;
  assign do_load  = ~StallE_i & ~FlushE_i;

  // Counter events; a stall only counts while a real instruction is being held.
  logic stall_evt;
  logic bubble_evt;

  assign stall_evt  = do_stall & ValidE_o;
  assign bubble_evt = do_flush | (do_load & ~ValidD_i);

  // Side-effect controls: squashed when the decode slot is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE_o    <= 1'b0;
      RegWriteE_o <= '0;
      MemWriteE_o <= '0;
      BranchE_o   <= 1'b0;
      JumpE_o     <= 1'b0;
    end else if (do_flush) begin
      ValidE_o    <= 1'b0;
      RegWriteE_o <= '0;
      MemWriteE_o <= '0;
      BranchE_o   <= 1'b0;
      JumpE_o     <= 1'b0;
    end else if (do_load) begin
      ValidE_o    <= ValidD_i;
      RegWriteE_o <= ValidD_i ? RegWriteD_i : 3'b000;
      MemWriteE_o <= ValidD_i ? MemWriteD_i : 2'b00;
      BranchE_o   <= ValidD_i & BranchD_i;
      JumpE_o     <= ValidD_i & JumpD_i;
    end
  end

  // Payload fields without side effects: cleared on flush for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ResultSrcE_o <= '0;
      ALUctrlE_o   <= '0;
      ALUsrcE_o    <= 1'b0;
      RD1E_o       <= '0;
      RD2E_o       <= '0;
      ImmExtE_o    <= '0;
      PCE_o        <= '0;
      PCPlus4E_o   <= '0;
      Rs1E_o       <= '0;
      Rs2E_o       <= '0;
      RdE_o        <= '0;
    end else if (do_flush) begin
      ResultSrcE_o <= '0;
      ALUctrlE_o   <= '0;
      ALUsrcE_o    <= 1'b0;
      RD1E_o       <= '0;
      RD2E_o       <= '0;
      ImmExtE_o    <= '0;
      PCE_o        <= '0;
      PCPlus4E_o   <= '0;
      Rs1E_o       <= '0;
      Rs2E_o       <= '0;
      RdE_o        <= '0;
    end else if (do_load) begin
      ResultSrcE_o <= ResultSrcD_i;
      ALUctrlE_o   <= ALUctrlD_i;
      ALUsrcE_o    <= ALUsrcD_i;
      RD1E_o       <= RD1D_i;
      RD2E_o       <= RD2D_i;
      ImmExtE_o    <= ImmExtD_i;
      PCE_o        <= PCD_i;
      PCPlus4E_o   <= PCPlus4D_i;
      Rs1E_o       <= Rs1D_i;
      Rs2E_o       <= Rs2D_i;
      RdE_o        <= RdD_i;
    end
  end

  // Performance counters; free-running, wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt_o  <= '0;
      BubbleCnt_o <= '0;
    end else begin
      if (stall_evt) begin
        StallCnt_o <= StallCnt_o + CNT_WIDTH'(1);
      end
      if (bubble_evt) begin
        BubbleCnt_o <= BubbleCnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: directed scenarios plus random
// traffic compared against a rule-level reference model.
module tb_decode_execute_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned NW = 16;
  localparam int unsigned CNT_MOD = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic StallE_i, FlushE_i, ValidD_i;
  logic [2:0] RegWriteD_i;
  logic [1:0] ResultSrcD_i, MemWriteD_i;
  logic [CW-1:0] ALUctrlD_i;
  logic ALUsrcD_i, BranchD_i, JumpD_i;
  logic [DW-1:0] RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i;
  logic [4:0] Rs1D_i, Rs2D_i, RdD_i;

  logic [2:0] RegWriteE_o;
  logic [1:0] ResultSrcE_o, MemWriteE_o;
  logic [CW-1:0] ALUctrlE_o;
  logic ALUsrcE_o, BranchE_o, JumpE_o;
  logic [DW-1:0] RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o;
  logic [4:0] Rs1E_o, Rs2E_o, RdE_o;
  logic ValidE_o;
  logic [NW-1:0] StallCnt_o, BubbleCnt_o;

  decode_execute_reg #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .StallE_i(StallE_i), .FlushE_i(FlushE_i), .ValidD_i(ValidD_i),
    .RegWriteD_i(RegWriteD_i), .ResultSrcD_i(ResultSrcD_i), .MemWriteD_i(MemWriteD_i),
    .ALUctrlD_i(ALUctrlD_i), .ALUsrcD_i(ALUsrcD_i), .BranchD_i(BranchD_i), .JumpD_i(JumpD_i),
    .RD1D_i(RD1D_i), .RD2D_i(RD2D_i), .ImmExtD_i(ImmExtD_i), .PCD_i(PCD_i),
    .PCPlus4D_i(PCPlus4D_i), .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdD_i(RdD_i),
    .RegWriteE_o(RegWriteE_o), .ResultSrcE_o(ResultSrcE_o), .MemWriteE_o(MemWriteE_o),
    .ALUctrlE_o(ALUctrlE_o), .ALUsrcE_o(ALUsrcE_o), .BranchE_o(BranchE_o), .JumpE_o(JumpE_o),
    .RD1E_o(RD1E_o), .RD2E_o(RD2E_o), .ImmExtE_o(ImmExtE_o), .PCE_o(PCE_o),
    .PCPlus4E_o(PCPlus4E_o), .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o), .RdE_o(RdE_o),
    .ValidE_o(ValidE_o), .StallCnt_o(StallCnt_o), .BubbleCnt_o(BubbleCnt_o)
  );

  // Reference model: the E slot as one record, counters as plain integers.
  typedef struct packed {
    logic          valid;
    logic [2:0]    rw;
    logic [1:0]    rsrc;
    logic [1:0]    mw;
    logic [CW-1:0] alu;
    logic          asrc;
    logic          br;
    logic          jp;
    logic [DW-1:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]    rs1, rs2, rd;
  } slot_t;

  slot_t       m;
  int unsigned m_stall_cnt;
  int unsigned m_bub_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "/ValidE"},     64'(ValidE_o),     64'(m.valid));
    chk({ctx, "/RegWriteE"},  64'(RegWriteE_o),  64'(m.rw));
    chk({ctx, "/ResultSrcE"}, 64'(ResultSrcE_o), 64'(m.rsrc));
    chk({ctx, "/MemWriteE"},  64'(MemWriteE_o),  64'(m.mw));
    chk({ctx, "/ALUctrlE"},   64'(ALUctrlE_o),   64'(m.alu));
    chk({ctx, "/ALUsrcE"},    64'(ALUsrcE_o),    64'(m.asrc));
    chk({ctx, "/BranchE"},    64'(BranchE_o),    64'(m.br));
    chk({ctx, "/JumpE"},      64'(JumpE_o),      64'(m.jp));
    chk({ctx, "/RD1E"},       64'(RD1E_o),       64'(m.rd1));
    chk({ctx, "/RD2E"},       64'(RD2E_o),       64'(m.rd2));
    chk({ctx, "/ImmExtE"},    64'(ImmExtE_o),    64'(m.imm));
    chk({ctx, "/PCE"},        64'(PCE_o),        64'(m.pc));
    chk({ctx, "/PCPlus4E"},   64'(PCPlus4E_o),   64'(m.pc4));
    chk({ctx, "/Rs1E"},       64'(Rs1E_o),       64'(m.rs1));
    chk({ctx, "/Rs2E"},       64'(Rs2E_o),       64'(m.rs2));
    chk({ctx, "/RdE"},        64'(RdE_o),        64'(m.rd));
    chk({ctx, "/StallCnt"},   64'(StallCnt_o),   64'(m_stall_cnt));
    chk({ctx, "/BubbleCnt"},  64'(BubbleCnt_o),  64'(m_bub_cnt));
  endtask

  task automatic model_reset();
    m = '0;
    m_stall_cnt = 0;
    m_bub_cnt = 0;
  endtask

  // Apply the flush > stall > load rules to the model for one rising edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (FlushE_i) begin
      m = '0;
      m_bub_cnt = (m_bub_cnt + 1) % CNT_MOD;
    end else if (StallE_i) begin
      if (m.valid) m_stall_cnt = (m_stall_cnt + 1) % CNT_MOD;
    end else begin
      m.valid = ValidD_i;
      m.rw = RegWriteD_i;   m.rsrc = ResultSrcD_i; m.mw = MemWriteD_i;
      m.alu = ALUctrlD_i;   m.asrc = ALUsrcD_i;    m.br = BranchD_i;
      m.jp = JumpD_i;
      m.rd1 = RD1D_i; m.rd2 = RD2D_i; m.imm = ImmExtD_i; m.pc = PCD_i; m.pc4 = PCPlus4D_i;
      m.rs1 = Rs1D_i; m.rs2 = Rs2D_i; m.rd = RdD_i;
      if (!ValidD_i) begin
        m.rw = '0; m.mw = '0; m.br = 1'b0; m.jp = 1'b0;
        m_bub_cnt = (m_bub_cnt + 1) % CNT_MOD;
      end
    end
  endtask

  // One clock: advance the model at the edge, sample #1 later.
  task automatic step(input string ctx, input bit do_chk);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) check_all(ctx);
  endtask

  task automatic rand_d();
    ValidD_i     = ($urandom_range(3) != 0);
    RegWriteD_i  = 3'($urandom);
    ResultSrcD_i = 2'($urandom);
    MemWriteD_i  = 2'($urandom);
    ALUctrlD_i   = CW'($urandom);
    ALUsrcD_i    = 1'($urandom);
    BranchD_i    = 1'($urandom);
    JumpD_i      = 1'($urandom);
    RD1D_i       = DW'($urandom);
    RD2D_i       = DW'($urandom);
    ImmExtD_i    = DW'($urandom);
    PCD_i        = DW'($urandom);
    PCPlus4D_i   = PCD_i + DW'(4);
    Rs1D_i       = 5'($urandom);
    Rs2D_i       = 5'($urandom);
    RdD_i        = 5'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    StallE_i = 1'b0;
    FlushE_i = 1'b0;
    rand_d();
    model_reset();

    // Reset values without any clock edge.
    #1;
    check_all("reset");
    #1 rst_n = 1'b1;

    // Basic load.
    rand_d();
    ValidD_i = 1'b1; RD1D_i = 32'h0000_0005; RegWriteD_i = 3'b001;
    step("load", 1'b1);
    chk("load/RD1E_const", 64'(RD1E_o), 64'h5);
    chk("load/RegWriteE_const", 64'(RegWriteE_o), 64'h1);
    chk("load/ValidE_const", 64'(ValidE_o), 64'h1);

    // Stall holds PC for three edges.
    rand_d();
    ValidD_i = 1'b1; PCD_i = 32'h100;
    step("stall_pre", 1'b1);
    StallE_i = 1'b1; PCD_i = 32'h104;
    for (int i = 0; i < 3; i++) step("stall", 1'b1);
    chk("stall/PCE_const", 64'(PCE_o), 64'h100);
    chk("stall/StallCnt_const", 64'(StallCnt_o), 64'd3);

    // Flush together with stall on a valid store.
    StallE_i = 1'b0;
    rand_d();
    ValidD_i = 1'b1; MemWriteD_i = 2'b01;
    step("flst_pre", 1'b1);
    chk("flst_pre/MemWriteE_const", 64'(MemWriteE_o), 64'h1);
    FlushE_i = 1'b1; StallE_i = 1'b1;
    step("flst", 1'b1);
    chk("flst/ValidE_const", 64'(ValidE_o), 64'h0);
    chk("flst/MemWriteE_const", 64'(MemWriteE_o), 64'h0);
    chk("flst/BubbleCnt_const", 64'(BubbleCnt_o), 64'd1);
    chk("flst/StallCnt_const", 64'(StallCnt_o), 64'd3);

    // Invalid decode slot squashes side effects.
    FlushE_i = 1'b0; StallE_i = 1'b0;
    rand_d();
    ValidD_i = 1'b0; MemWriteD_i = 2'b11; JumpD_i = 1'b1;
    step("inval", 1'b1);
    chk("inval/MemWriteE_const", 64'(MemWriteE_o), 64'h0);
    chk("inval/JumpE_const", 64'(JumpE_o), 64'h0);
    chk("inval/ValidE_const", 64'(ValidE_o), 64'h0);
    chk("inval/BubbleCnt_const", 64'(BubbleCnt_o), 64'd2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      StallE_i = ($urandom_range(3) == 0);
      FlushE_i = ($urandom_range(7) == 0);
      step("rand", 1'b1);
    end

    // Async reset in the middle of a stall, then stall/flush ignored under reset.
    rand_d();
    ValidD_i = 1'b1; StallE_i = 1'b0; FlushE_i = 1'b0;
    step("rst_pre", 1'b1);
    StallE_i = 1'b1;
    step("rst_stall", 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    FlushE_i = 1'b1;
    step("rst_held", 1'b1);
    rst_n = 1'b1;
    StallE_i = 1'b0; FlushE_i = 1'b0;
    rand_d();
    ValidD_i = 1'b1;
    step("rst_release", 1'b1);
    chk("rst_release/ValidE_const", 64'(ValidE_o), 64'h1);

    // Bubble counter wrap via consecutive flushes from a clean reset.
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    FlushE_i = 1'b1;
    for (int i = 0; i < 65535; i++) step("wrap_fill", 1'b0);
    chk("wrap/BubbleCnt_full", 64'(BubbleCnt_o), 64'hFFFF);
    step("wrap", 1'b1);
    chk("wrap/BubbleCnt_zero", 64'(BubbleCnt_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
